// File: rtl/mpmc10_rd_strip_collect.sv
// Collects a burst of memory-interface read strips into one wide line buffer.
// Optional inactivity timeout enabled by defining MPMC10_RD_TIMEOUT_EN.
module mpmc10_rd_strip_collect #(
   parameter int WID    = 128,
   parameter int NSTRIP = 4
) (
   input  logic                  rst,
   input  logic                  clk,
   input  logic                  start,
   input  logic [5:0]            num_strips,
   input  logic                  app_rd_data_valid,
   input  logic [WID-1:0]        app_rd_data,
   output logic [5:0]            strip_cnt,
   output logic [WID*NSTRIP-1:0] line,
   output logic                  busy,
   output logic                  rd_done,
   output logic                  rd_stray,
   output logic                  rd_err
);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t         state_q;
   logic [5:0]     cnt_q;
   logic [5:0]     cnt_d;
   logic [5:0]     num_q;
   logic           rd_done_q;
   logic           rd_stray_q;
   logic [WID-1:0] strip_q [NSTRIP];
   logic           beat;
   logic           last_beat;
   logic           timeout;

   assign beat      = (state_q == COLLECT) && app_rd_data_valid;
   assign cnt_d     = cnt_q + 6'd1;
   assign last_beat = beat && (cnt_q == num_q);

`ifdef MPMC10_RD_TIMEOUT_EN
   logic [7:0] to_q;
   logic       rd_err_q;

   // The 255th quiet COLLECT cycle is the one that would bring the counter to 255.
   assign timeout = (state_q == COLLECT) && !app_rd_data_valid && (to_q == 8'd254);

   always_ff @(posedge clk) begin
      if (rst) begin
         to_q     <= 8'd0;
         rd_err_q <= 1'b0;
      end else begin
         rd_err_q <= timeout;
         if ((state_q != COLLECT) || app_rd_data_valid || timeout) begin
            to_q <= 8'd0;
         end else begin
            to_q <= to_q + 8'd1;
         end
      end
   end

   assign rd_err = rd_err_q;
`else
   assign timeout = 1'b0;
   assign rd_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 6'd0;
         num_q      <= 6'd0;
         rd_done_q  <= 1'b0;
         rd_stray_q <= 1'b0;
      end else begin
         rd_done_q  <= last_beat;
         rd_stray_q <= app_rd_data_valid && (state_q != COLLECT);
         case (state_q)
            IDLE: begin
               if (start) begin
                  num_q   <= num_strips;
                  cnt_q   <= 6'd0;
                  state_q <= COLLECT;
               end
            end
            COLLECT: begin
               if (beat) begin
                  cnt_q <= cnt_d;
                  if (cnt_q == num_q) begin
                     state_q <= DONE;
                  end
               end else if (timeout) begin
                  state_q <= IDLE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Beats past the buffer depth match no slot, so they are counted but dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSTRIP; i++) begin
            strip_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NSTRIP; i++) begin
            if (beat && (cnt_q == 6'(i))) begin
               strip_q[i] <= app_rd_data;
            end
         end
      end
   end

   for (genvar gi = 0; gi < NSTRIP; gi++) begin : g_line
      assign line[gi*WID +: WID] = strip_q[gi];
   end

   assign strip_cnt = cnt_q;
   assign busy      = (state_q == COLLECT);
   assign rd_done   = rd_done_q;
   assign rd_stray  = rd_stray_q;

endmodule
